// File: rtl/ddr_cmd_arbiter.sv
// DDR user-port arbiter for 3 requesters with an in-order read tag FIFO.
// Define DDR_ARB_RR_EN for round-robin arbitration instead of fixed 0>1>2.
module ddr_cmd_arbiter #(
  parameter int NUM_REQ   = 3,
  parameter int ADDR_W    = 30,
  parameter int TAG_DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_en,
  input  logic [NUM_REQ*3-1:0]      req_cmd,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        req_rdy,
  output logic [NUM_REQ-1:0]        req_rd_valid,
  input  logic                      ddr_rdy,
  input  logic                      ddr_rd_data_valid,
  output logic                      ddr_en,
  output logic [2:0]                ddr_cmd,
  output logic [ADDR_W-1:0]         ddr_addr,
  output logic                      err_orphan_valid,
  output logic                      busy
);

  localparam int PW    = $clog2(TAG_DEPTH);
  localparam int CNT_W = PW + 1;
  localparam logic [2:0] CMD_RD = 3'b001;
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]        state;
  logic [2:0]        gnt_q;
  logic [1:0]        g_idx;
  logic [1:0]        win;
  logic [2:0]        cmd_g;
  logic [ADDR_W-1:0] addr_g;
  logic              granted;
  logic              is_read;
  logic              stall;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;

  logic [1:0]        tag_mem [TAG_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CNT_W-1:0]  count;

  always_comb begin
    g_idx  = 2'd0;
    cmd_g  = req_cmd[2:0];
    addr_g = req_addr[ADDR_W-1:0];
    unique case (1'b1)
      gnt_q[0]: begin
        g_idx  = 2'd0;
        cmd_g  = req_cmd[2:0];
        addr_g = req_addr[ADDR_W-1:0];
      end
      gnt_q[1]: begin
        g_idx  = 2'd1;
        cmd_g  = req_cmd[5:3];
        addr_g = req_addr[2*ADDR_W-1:ADDR_W];
      end
      gnt_q[2]: begin
        g_idx  = 2'd2;
        cmd_g  = req_cmd[8:6];
        addr_g = req_addr[3*ADDR_W-1:2*ADDR_W];
      end
      default: ;
    endcase
  end

`ifdef DDR_ARB_RR_EN
  logic [1:0] last_q;
  logic [1:0] c0;
  logic [1:0] c1;
  logic [1:0] c2;

  // search order rotates to start just after the previous winner
  always_comb begin
    c0 = (last_q == 2'd2) ? 2'd0 : last_q + 2'd1;
    c1 = (c0 == 2'd2) ? 2'd0 : c0 + 2'd1;
    c2 = (c1 == 2'd2) ? 2'd0 : c1 + 2'd1;
    if (req[c0])      win = c0;
    else if (req[c1]) win = c1;
    else              win = c2;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      last_q <= 2'd2;
    else if (state == IDLE && |req)
      last_q <= win;
  end
`else
  always_comb begin
    if (req[0])      win = 2'd0;
    else if (req[1]) win = 2'd1;
    else             win = 2'd2;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt_q <= 3'b000;
    end else begin
      unique case (state)
        IDLE: if (|req) begin
          gnt_q <= 3'b001 << win;
          state <= GRANT;
        end
        GRANT: if (!(|(req & gnt_q))) begin
          gnt_q <= 3'b000;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign granted = (state == GRANT);
  assign full    = (count == CNT_W'(TAG_DEPTH));
  assign empty   = (count == '0);
  assign is_read = (cmd_g == CMD_RD);
  assign stall   = is_read & full;

  assign gnt      = gnt_q;
  assign ddr_en   = granted & req_en[g_idx] & ~stall;
  assign ddr_cmd  = granted ? cmd_g : CMD_RD;
  assign ddr_addr = granted ? addr_g : '0;
  assign req_rdy  = granted ? (gnt_q & {3{ddr_rdy & ~stall}}) : 3'b000;

  assign push = ddr_en & ddr_rdy & is_read;
  assign pop  = ddr_rd_data_valid & ~empty;

  assign req_rd_valid = pop ? (3'b001 << tag_mem[rd_ptr]) : 3'b000;
  assign busy = (|gnt_q) | ~empty;

  always_ff @(posedge clk) begin
    if (push)
      tag_mem[wr_ptr] <= g_idx;
  end

  // a push into an empty FIFO is not seen by the same-cycle pop
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      err_orphan_valid <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)
        count <= count + CNT_W'(1);
      else if (pop && !push)
        count <= count - CNT_W'(1);
      if (ddr_rd_data_valid && empty)
        err_orphan_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ddr_cmd_arbiter.sv
// Bench for ddr_cmd_arbiter: directed checks plus random traffic
// compared every cycle against a queue-based model.
module tb_ddr_cmd_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req;
  logic [2:0]  req_en;
  logic [8:0]  req_cmd;
  logic [89:0] req_addr;
  logic [2:0]  gnt;
  logic [2:0]  req_rdy;
  logic [2:0]  req_rd_valid;
  logic        ddr_rdy;
  logic        ddr_rd_data_valid;
  logic        ddr_en;
  logic [2:0]  ddr_cmd;
  logic [29:0] ddr_addr;
  logic        err_orphan_valid;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  ddr_cmd_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req(req), .req_en(req_en),
    .req_cmd(req_cmd), .req_addr(req_addr),
    .gnt(gnt), .req_rdy(req_rdy),
    .req_rd_valid(req_rd_valid),
    .ddr_rdy(ddr_rdy),
    .ddr_rd_data_valid(ddr_rd_data_valid),
    .ddr_en(ddr_en), .ddr_cmd(ddr_cmd),
    .ddr_addr(ddr_addr),
    .err_orphan_valid(err_orphan_valid),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // model state: owner index (-1 idle), queue of outstanding read owners
  int   m_owner = -1;
  int   m_last  = 2;
  bit   m_err   = 1'b0;
  int   m_q[$];

  logic [2:0]  e_gnt, e_rdy, e_rdv, e_cmd;
  logic        e_en, e_err, e_busy;
  logic [29:0] e_addr;

  function automatic void calc();
    logic [2:0] c;
    bit blk;
    e_gnt  = '0;
    e_rdy  = '0;
    e_rdv  = '0;
    e_en   = 1'b0;
    e_cmd  = 3'b001;
    e_addr = '0;
    if (m_owner >= 0) begin
      e_gnt[m_owner] = 1'b1;
      c = req_cmd[m_owner*3 +: 3];
      e_cmd = c;
      e_addr = req_addr[m_owner*30 +: 30];
      blk = (c == 3'b001) && (m_q.size() == 16);
      e_en = req_en[m_owner] && !blk;
      e_rdy[m_owner] = ddr_rdy && !blk;
    end
    if (ddr_rd_data_valid && m_q.size() > 0)
      e_rdv[m_q[0]] = 1'b1;
    e_err  = m_err;
    e_busy = (m_owner >= 0) || (m_q.size() > 0);
  endfunction

  function automatic int pick(logic [2:0] r);
`ifdef DDR_ARB_RR_EN
    for (int k = 1; k <= 3; k++) begin
      int c;
      c = (m_last + k) % 3;
      if (r[c]) return c;
    end
`else
    for (int c = 0; c < 3; c++)
      if (r[c]) return c;
`endif
    return -1;
  endfunction

  always @(posedge clk) begin
    calc();
    if (!rst_n) begin
      m_owner = -1;
      m_last  = 2;
      m_err   = 1'b0;
      m_q.delete();
    end else begin
      if (ddr_rd_data_valid) begin
        if (m_q.size() > 0) void'(m_q.pop_front());
        else m_err = 1'b1;
      end
      if (e_en && ddr_rdy && e_cmd == 3'b001)
        m_q.push_back(m_owner);
      if (m_owner < 0) begin
        if (req != 3'b000) begin
          m_owner = pick(req);
          m_last  = m_owner;
        end
      end else if (!req[m_owner]) begin
        m_owner = -1;
      end
    end
  end

  always @(negedge clk) begin
    calc();
    vectors++;
    if (gnt !== e_gnt || req_rdy !== e_rdy ||
        req_rd_valid !== e_rdv || ddr_en !== e_en ||
        ddr_cmd !== e_cmd || ddr_addr !== e_addr ||
        err_orphan_valid !== e_err || busy !== e_busy) begin
      miscompares++;
      $display("FAIL model_cmp t=%0t act gnt=%b rdy=%b rdv=%b en=%b cmd=%b addr=%h err=%b busy=%b exp gnt=%b rdy=%b rdv=%b en=%b cmd=%b addr=%h err=%b busy=%b",
        $time, gnt, req_rdy, req_rd_valid, ddr_en, ddr_cmd,
        ddr_addr, err_orphan_valid, busy, e_gnt, e_rdy, e_rdv,
        e_en, e_cmd, e_addr, e_err, e_busy);
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int r, input logic rd);
    req_cmd[r*3 +: 3] = rd ? 3'b001 : 3'b000;
  endtask

  logic [2:0] route_exp [5];

  initial begin
    rst_n = 1'b0;
    req = '0;
    req_en = '0;
    req_cmd = '0;
    req_addr = '0;
    ddr_rdy = 1'b0;
    ddr_rd_data_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #2;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cmd", 32'(ddr_cmd), 1);
    chk("rst_en", 32'(ddr_en), 0);
    chk("rst_err", 32'(err_orphan_valid), 0);

    // single requester, four reads
    req = 3'b010;
    tick();
    #2;
    chk("t1_gnt", 32'(gnt), 32'b010);
    for (int k = 0; k < 4; k++) begin
      req_en = 3'b010;
      set_rd(1, 1'b1);
      req_addr[59:30] = 30'h100 + 30'(8 * k);
      ddr_rdy = 1'b1;
      #1;
      chk("t1_addr", 32'(ddr_addr), 32'h100 + 32'(8 * k));
      chk("t1_en", 32'(ddr_en), 1);
      tick();
    end
    req_en = '0;
    for (int k = 0; k < 4; k++) begin
      ddr_rd_data_valid = 1'b1;
      if (k == 3) req = 3'b000;
      #1;
      chk("t1_rdv", 32'(req_rd_valid), 32'b010);
      tick();
    end
    ddr_rd_data_valid = 1'b0;
    #1;
    chk("t1_busy", 32'(busy), 0);

    // routing across two owners
    req = 3'b001;
    tick();
    req_en = 3'b001;
    set_rd(0, 1'b1);
    repeat (3) tick();
    req_en = '0;
    req = 3'b000;
    tick();
    req = 3'b010;
    tick();
    req_en = 3'b010;
    set_rd(1, 1'b1);
    repeat (2) tick();
    req_en = '0;
    req = 3'b000;
    tick();
    route_exp = '{3'b001, 3'b001, 3'b001, 3'b010, 3'b010};
    for (int k = 0; k < 5; k++) begin
      ddr_rd_data_valid = 1'b1;
      #1;
      chk("t3_route", 32'(req_rd_valid), 32'(route_exp[k]));
      tick();
    end
    ddr_rd_data_valid = 1'b0;

    // tag FIFO full
    req = 3'b001;
    tick();
    req_en = 3'b001;
    set_rd(0, 1'b1);
    ddr_rdy = 1'b1;
    repeat (16) tick();
    #1;
    chk("t4_stall_en", 32'(ddr_en), 0);
    chk("t4_stall_rdy", 32'(req_rdy), 0);
    set_rd(0, 1'b0);
    #1;
    chk("t4_write_en", 32'(ddr_en), 1);
    tick();
    set_rd(0, 1'b1);
    ddr_rd_data_valid = 1'b1;
    #1;
    chk("t4_pop_stall", 32'(ddr_en), 0);
    chk("t4_pop_rdv", 32'(req_rd_valid), 32'b001);
    tick();
    ddr_rd_data_valid = 1'b0;
    #1;
    chk("t4_reenable", 32'(ddr_en), 1);
    tick();
    req_en = '0;
    ddr_rd_data_valid = 1'b1;
    repeat (16) tick();
    ddr_rd_data_valid = 1'b0;
    req = 3'b000;
    tick();
    #1;
    chk("t4_busy", 32'(busy), 0);

    // orphan return
    ddr_rd_data_valid = 1'b1;
    #1;
    chk("t5_rdv", 32'(req_rd_valid), 0);
    tick();
    ddr_rd_data_valid = 1'b0;
    #1;
    chk("t5_err", 32'(err_orphan_valid), 1);
    tick();
    chk("t5_err_hold", 32'(err_orphan_valid), 1);

    // reset mid-transaction
    req = 3'b100;
    tick();
    req_en = 3'b100;
    set_rd(2, 1'b1);
    repeat (5) tick();
    req_en = '0;
    #1;
    chk("t6_busy_pre", 32'(busy), 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req = 3'b000;
    #1;
    chk("t6_gnt", 32'(gnt), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_err", 32'(err_orphan_valid), 0);

    // grant sequence from reset pointer
    req = 3'b111;
    tick();
    #1;
    chk("t2_g0", 32'(gnt), 32'b001);
    req = 3'b110;
    tick();
    #1;
    chk("t2_rel0", 32'(gnt), 0);
    tick();
    #1;
    chk("t2_g1", 32'(gnt), 32'b010);
    req = 3'b100;
    tick();
    tick();
    #1;
    chk("t2_g2", 32'(gnt), 32'b100);
    req = 3'b011;
    tick();
    tick();
    #1;
    chk("t2_g0_again", 32'(gnt), 32'b001);
    req = 3'b000;
    tick();

    // random traffic
    for (int n = 0; n < 4000; n++) begin
      for (int r = 0; r < 3; r++) begin
        if ($urandom_range(15) == 0) req[r] = ~req[r];
        set_rd(r, $urandom_range(3) != 0);
      end
      req_en = 3'($urandom);
      req_addr = {30'($urandom), 30'($urandom), 30'($urandom)};
      ddr_rdy = $urandom_range(3) != 0;
      ddr_rd_data_valid = (n < 2000) ? ($urandom_range(7) == 0)
                                     : ($urandom_range(1) == 0);
      rst_n = $urandom_range(699) != 0;
      tick();
    end
    rst_n = 1'b1;
    req = '0;
    req_en = '0;
    ddr_rd_data_valid = 1'b0;
    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
